// File: rtl/uart_rx_buffer_if.sv
// Valid/ready byte stream from the receive buffer to its consumer.
interface uart_rx_buffer_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  m_valid;
  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_ready;

  modport master (output m_valid, output m_data, input m_ready);
  modport slave  (input m_valid, input m_data, output m_ready);
endinterface

// File: rtl/uart_rx_buffer.sv
// Receive-side FIFO behind the UART core: one byte captured per rx_rdy rising
// edge, first-word fall-through stream out, level/overrun/timeout/irq status.
module uart_rx_buffer #(
  parameter int DATA_WIDTH     = 8,
  parameter int DEPTH_LOG2     = 4,
  parameter int THRESHOLD      = 8,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  PCLK,
  input  logic                  PRESETN,
  input  logic                  rx_rdy,
  input  logic [DATA_WIDTH-1:0] rx_data,
  input  logic                  flush,
  input  logic                  clr_overrun,
  uart_rx_buffer_if.master      m,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  overrun,
  output logic                  timeout,
  output logic                  irq
);
  localparam int DEPTH  = 1 << DEPTH_LOG2;
  localparam int IDLE_W = $clog2(TIMEOUT_CYCLES) + 1;

  localparam logic [DEPTH_LOG2:0] FULL_LVL = (DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0] THR_LVL  = (DEPTH_LOG2 + 1)'(THRESHOLD);
  localparam logic [DEPTH_LOG2:0] LVL_ONE  = (DEPTH_LOG2 + 1)'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE = DEPTH_LOG2'(1);
  localparam logic [IDLE_W-1:0]   IDLE_MAX = IDLE_W'(TIMEOUT_CYCLES);
  localparam logic [IDLE_W-1:0]   IDLE_ONE = IDLE_W'(1);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic                  rdy_q;
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   level_q, level_d;
  logic                  overrun_q, overrun_d;
  logic [IDLE_W-1:0]     idle_q, idle_d;

  logic push_req_s;
  logic pop_s;
  logic full_s;
  logic do_push_s;
  logic do_pop_s;
  logic drop_s;

  assign push_req_s = rx_rdy & ~rdy_q;
  assign full_s     = (level_q == FULL_LVL);
  assign pop_s      = m.m_valid & m.m_ready;
  // A push at full only fits when a pop frees the head slot in the same cycle.
  assign do_push_s  = ~flush & push_req_s & (~full_s | pop_s);
  assign do_pop_s   = ~flush & pop_s;
  assign drop_s     = ~flush & push_req_s & full_s & ~pop_s;

  // Next-state for pointers, level, overrun and idle counter.
  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    level_d   = level_q;
    overrun_d = overrun_q;
    idle_d    = idle_q;

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (do_push_s) begin
        wr_ptr_d = wr_ptr_q + PTR_ONE;
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (do_pop_s) begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      if (do_push_s && !do_pop_s) begin
        level_d = level_q + LVL_ONE;
      end else if (do_pop_s && !do_push_s) begin
        level_d = level_q - LVL_ONE;
      end else begin
        level_d = level_q;
      end
    end

    if (drop_s) begin
      overrun_d = 1'b1;
    end else if (clr_overrun) begin
      overrun_d = 1'b0;
    end else begin
      overrun_d = overrun_q;
    end

    if (flush || (level_q == '0) || push_req_s || pop_s) begin
      idle_d = '0;
    end else if (idle_q != IDLE_MAX) begin
      idle_d = idle_q + IDLE_ONE;
    end else begin
      idle_d = idle_q;
    end
  end

  // Control state registers.
  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      rdy_q     <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      overrun_q <= 1'b0;
      idle_q    <= '0;
    end else begin
      rdy_q     <= rx_rdy;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      level_q   <= level_d;
      overrun_q <= overrun_d;
      idle_q    <= idle_d;
    end
  end

  // Storage array; contents need no reset since level gates visibility.
  always_ff @(posedge PCLK) begin
    if (do_push_s) begin
      mem_q[wr_ptr_q] <= rx_data;
    end
  end

  assign m.m_valid = (level_q != '0);
  assign m.m_data  = m.m_valid ? mem_q[rd_ptr_q] : '0;
  assign level     = level_q;
  assign overrun   = overrun_q;
  assign timeout   = (idle_q == IDLE_MAX);
  assign irq       = (level_q >= THR_LVL) | timeout;

endmodule

// File: tb/tb_uart_rx_buffer.sv
// Directed self-checking bench for uart_rx_buffer (DEPTH=16, THRESHOLD=8,
// TIMEOUT_CYCLES=1024).
module tb_uart_rx_buffer;
  logic       clk;
  logic       rst_n;
  logic       rx_rdy;
  logic [7:0] rx_data;
  logic       flush;
  logic       clr_overrun;
  logic [4:0] level;
  logic       overrun;
  logic       timeout;
  logic       irq;

  int tests_run;
  int tests_failed;

  uart_rx_buffer_if #(.DATA_WIDTH(8)) m_if ();

  uart_rx_buffer #(
    .DATA_WIDTH(8), .DEPTH_LOG2(4), .THRESHOLD(8), .TIMEOUT_CYCLES(1024)
  ) dut (
    .PCLK(clk), .PRESETN(rst_n), .rx_rdy(rx_rdy), .rx_data(rx_data),
    .flush(flush), .clr_overrun(clr_overrun), .m(m_if),
    .level(level), .overrun(overrun), .timeout(timeout), .irq(irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One rx_rdy pulse: rising edge captured at the first tick, low for the second.
  task automatic push_byte(input logic [7:0] b);
    rx_rdy  = 1'b1;
    rx_data = b;
    tick();
    rx_rdy  = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    tests_run++;
    if (level !== 5'd0 || m_if.m_valid !== 1'b0 || m_if.m_data !== 8'h00) begin
      tests_failed++;
      $display("FAIL reset_fifo: level=%0d valid=%b data=%h, want 0/0/00", level, m_if.m_valid, m_if.m_data);
    end
    tests_run++;
    if (overrun !== 1'b0 || timeout !== 1'b0 || irq !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_flags: ovr=%b to=%b irq=%b, want 0/0/0", overrun, timeout, irq);
    end
  endtask

  task automatic test_basic();
    logic [7:0] exp_b [3];
    exp_b[0] = 8'h41; exp_b[1] = 8'h42; exp_b[2] = 8'h43;
    for (int i = 0; i < 3; i++) push_byte(exp_b[i]);
    tests_run++;
    if (level !== 5'd3 || m_if.m_valid !== 1'b1 || m_if.m_data !== 8'h41) begin
      tests_failed++;
      $display("FAIL basic_fill: level=%0d valid=%b data=%h, want 3/1/41", level, m_if.m_valid, m_if.m_data);
    end
    m_if.m_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tests_run++;
      if (m_if.m_valid !== 1'b1 || m_if.m_data !== exp_b[i]) begin
        tests_failed++;
        $display("FAIL basic_drain%0d: valid=%b data=%h, want 1/%h", i, m_if.m_valid, m_if.m_data, exp_b[i]);
      end
      tick();
    end
    m_if.m_ready = 1'b0;
    tests_run++;
    if (m_if.m_valid !== 1'b0 || m_if.m_data !== 8'h00 || level !== 5'd0) begin
      tests_failed++;
      $display("FAIL basic_empty: valid=%b data=%h level=%0d, want 0/00/0", m_if.m_valid, m_if.m_data, level);
    end
  endtask

  task automatic test_long_pulse();
    rx_rdy  = 1'b1;
    rx_data = 8'h55;
    for (int i = 0; i < 10; i++) tick();
    rx_rdy = 1'b0;
    tick();
    tests_run++;
    if (level !== 5'd1 || m_if.m_data !== 8'h55) begin
      tests_failed++;
      $display("FAIL long_pulse: level=%0d data=%h, want 1/55", level, m_if.m_data);
    end
    m_if.m_ready = 1'b1;
    tick();
    m_if.m_ready = 1'b0;
    tests_run++;
    if (level !== 5'd0 || m_if.m_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL long_pulse_pop: level=%0d valid=%b, want 0/0", level, m_if.m_valid);
    end
  endtask

  task automatic test_overrun();
    for (int i = 0; i < 16; i++) push_byte(8'(i));
    push_byte(8'hAA);
    tests_run++;
    if (level !== 5'd16 || overrun !== 1'b1 || irq !== 1'b1) begin
      tests_failed++;
      $display("FAIL overrun_set: level=%0d ovr=%b irq=%b, want 16/1/1", level, overrun, irq);
    end
    m_if.m_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tests_run++;
      if (m_if.m_valid !== 1'b1 || m_if.m_data !== 8'(i)) begin
        tests_failed++;
        $display("FAIL overrun_drain%0d: valid=%b data=%h, want 1/%h", i, m_if.m_valid, m_if.m_data, 8'(i));
      end
      tick();
    end
    m_if.m_ready = 1'b0;
    tests_run++;
    if (m_if.m_valid !== 1'b0 || level !== 5'd0) begin
      tests_failed++;
      $display("FAIL overrun_dropped: valid=%b level=%0d, want 0/0 (0xAA must be absent)", m_if.m_valid, level);
    end
    clr_overrun = 1'b1;
    tick();
    clr_overrun = 1'b0;
    tests_run++;
    if (overrun !== 1'b0) begin
      tests_failed++;
      $display("FAIL overrun_clear: ovr=%b, want 0", overrun);
    end
  endtask

  task automatic test_full_push_pop();
    for (int i = 0; i < 16; i++) push_byte(8'h10 + 8'(i));
    rx_rdy       = 1'b1;
    rx_data      = 8'h99;
    m_if.m_ready = 1'b1;
    tick();
    rx_rdy       = 1'b0;
    m_if.m_ready = 1'b0;
    tests_run++;
    if (level !== 5'd16 || overrun !== 1'b0 || m_if.m_data !== 8'h11) begin
      tests_failed++;
      $display("FAIL full_push_pop: level=%0d ovr=%b data=%h, want 16/0/11", level, overrun, m_if.m_data);
    end
    tick();
    m_if.m_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      logic [7:0] e;
      e = (i == 15) ? 8'h99 : 8'h11 + 8'(i);
      tests_run++;
      if (m_if.m_valid !== 1'b1 || m_if.m_data !== e) begin
        tests_failed++;
        $display("FAIL wrap_drain%0d: valid=%b data=%h, want 1/%h", i, m_if.m_valid, m_if.m_data, e);
      end
      tick();
    end
    m_if.m_ready = 1'b0;
    tests_run++;
    if (m_if.m_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL wrap_empty: valid=%b, want 0", m_if.m_valid);
    end
  endtask

  task automatic test_timeout();
    int early;
    early = 0;
    push_byte(8'h01);
    rx_rdy  = 1'b1;
    rx_data = 8'h02;
    tick();
    rx_rdy = 1'b0;
    for (int k = 1; k < 1024; k++) begin
      tick();
      if (timeout !== 1'b0 || irq !== 1'b0) early++;
    end
    tests_run++;
    if (early != 0) begin
      tests_failed++;
      $display("FAIL timeout_early: %0d idle cycles showed timeout/irq, want 0", early);
    end
    tick();
    tests_run++;
    if (timeout !== 1'b1 || irq !== 1'b1) begin
      tests_failed++;
      $display("FAIL timeout_rise: to=%b irq=%b, want 1/1", timeout, irq);
    end
    m_if.m_ready = 1'b1;
    tick();
    m_if.m_ready = 1'b0;
    tests_run++;
    if (timeout !== 1'b0 || irq !== 1'b0 || level !== 5'd1) begin
      tests_failed++;
      $display("FAIL timeout_clear: to=%b irq=%b level=%0d, want 0/0/1", timeout, irq, level);
    end
    for (int i = 0; i < 7; i++) push_byte(8'h20 + 8'(i));
    tests_run++;
    if (irq !== 1'b1 || timeout !== 1'b0 || level !== 5'd8) begin
      tests_failed++;
      $display("FAIL threshold_irq: irq=%b to=%b level=%0d, want 1/0/8", irq, timeout, level);
    end
    flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  task automatic test_flush();
    for (int i = 0; i < 5; i++) push_byte(8'h30 + 8'(i));
    flush   = 1'b1;
    rx_rdy  = 1'b1;
    rx_data = 8'h66;
    tick();
    flush  = 1'b0;
    rx_rdy = 1'b0;
    tick();
    tests_run++;
    if (level !== 5'd0 || m_if.m_valid !== 1'b0 || overrun !== 1'b0) begin
      tests_failed++;
      $display("FAIL flush_clear: level=%0d valid=%b ovr=%b, want 0/0/0", level, m_if.m_valid, overrun);
    end
    push_byte(8'h77);
    tests_run++;
    if (level !== 5'd1 || m_if.m_data !== 8'h77) begin
      tests_failed++;
      $display("FAIL flush_not_stored: level=%0d data=%h, want 1/77", level, m_if.m_data);
    end
    for (int i = 0; i < 16; i++) push_byte(8'h40 + 8'(i));
    flush   = 1'b1;
    rx_rdy  = 1'b1;
    rx_data = 8'h88;
    tick();
    flush  = 1'b0;
    rx_rdy = 1'b0;
    tick();
    tests_run++;
    if (overrun !== 1'b1 || level !== 5'd0) begin
      tests_failed++;
      $display("FAIL flush_keeps_overrun: ovr=%b level=%0d, want 1/0", overrun, level);
    end
    clr_overrun = 1'b1;
    tick();
    clr_overrun = 1'b0;
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 4; i++) push_byte(8'h50 + 8'(i));
    #2;
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (level !== 5'd0 || m_if.m_valid !== 1'b0 || m_if.m_data !== 8'h00) begin
      tests_failed++;
      $display("FAIL reset_async: level=%0d valid=%b data=%h, want 0/0/00", level, m_if.m_valid, m_if.m_data);
    end
    rx_rdy  = 1'b1;
    rx_data = 8'hEE;
    tick();
    rx_rdy = 1'b0;
    rst_n  = 1'b1;
    tick();
    tests_run++;
    if (level !== 5'd0) begin
      tests_failed++;
      $display("FAIL reset_lost_byte: level=%0d, want 0", level);
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst_n        = 1'b0;
    rx_rdy       = 1'b0;
    rx_data      = 8'h00;
    flush        = 1'b0;
    clr_overrun  = 1'b0;
    m_if.m_ready = 1'b0;

    test_reset();
    test_basic();
    test_long_pulse();
    test_overrun();
    test_full_push_pop();
    test_timeout();
    test_flush();
    test_reset_mid();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
